adder_byte_seq: RTL and testbench

- Sequencer that computes a wide (8*NBYTES-bit) addition by time-multiplexing the team's existing 8-bit adder datapath: ports iData_a[7:0], iData_b[7:0], iC in; oData[7:0], oData_C out.
- Accepts wide operands through a valid/ready handshake.
- Feeds one byte pair per cycle to the adder, LSB first, and chains carry through an internal register.
- Presents the wide sum and final carry through an output valid/ready handshake.
- Sits between a requester (CPU-style datapath or bench) and one Adder instance.
- The Adder is external: this block only drives and samples its ports.

---
 rtl/adder_byte_seq.sv | 172 +++++++++++++++++
 tb/tb_adder_byte_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_byte_seq.sv
`default_nettype none
// ============================================================================
// Module   : adder_byte_seq
// Purpose  : Computes a wide (8*NBYTES-bit) add by stepping one byte pair per
//            cycle through an external 8-bit Adder, LSB first, chaining the
//            carry through an internal register. Requests and results both
//            use valid/ready handshakes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   NBYTES      number of 8-bit slices per operation (1..8)
// Build option:
//   ADD_BYTE_SEQ_SUB_EN  when defined, iSub=1 selects A - B - iC
//                        (iC acts as borrow-in, oCarry=1 means no borrow).
//                        When undefined the block is add-only and iSub is
//                        ignored.
// Ports:
//   iClk, iRst_n        clock (rising edge), asynchronous active-low reset
//   iValid / oReady     request handshake; iA, iB, iC, iSub sampled on accept
//   oAdd_a/b/c          byte pair and carry driven to the Adder (0 unless RUN)
//   iAdd_sum/iAdd_cout  combinational Adder response
//   oValid / iReady     result handshake; oSum, oCarry held while oValid=1
// ============================================================================
module adder_byte_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [8*NBYTES-1:0]   iA,
  input  logic [8*NBYTES-1:0]   iB,
  input  logic                  iC,
  input  logic                  iSub,
  output logic [7:0]            oAdd_a,
  output logic [7:0]            oAdd_b,
  output logic                  oAdd_c,
  input  logic [7:0]            iAdd_sum,
  input  logic                  iAdd_cout,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [8*NBYTES-1:0]   oSum,
  output logic                  oCarry
);

  // Byte index needs at least one bit even for a single-slice build.
  localparam int c_IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NBYTES - 1);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_RUN  = 2'd1;
  localparam logic [1:0] c_S_DONE = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_stateNext;
  logic [c_IDX_W-1:0]   r_idx;
  logic                 r_carry;
  logic [8*NBYTES-1:0]  r_opA;
  logic [8*NBYTES-1:0]  r_opB;
  logic [8*NBYTES-1:0]  r_sum;
  logic                 r_carryOut;

  logic                 w_accept;
  logic                 w_lastByte;
  logic                 w_initCarry;
  logic [7:0]           w_byteB;

  assign w_accept   = iValid && (r_state == c_S_IDLE);
  assign w_lastByte = (r_idx == c_LAST_IDX);

`ifdef ADD_BYTE_SEQ_SUB_EN
  // Subtraction is A + ~B + ~borrow: invert the B slice and the initial carry.
  logic r_sub;

  assign w_initCarry = iSub ? ~iC : iC;
  assign w_byteB     = r_sub ? ~r_opB[8*r_idx +: 8] : r_opB[8*r_idx +: 8];

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_sub <= 1'b0;
    end else if (w_accept) begin
      r_sub <= iSub;
    end
  end
`else
  // Add-only build: iSub stays on the port but drives nothing.
  logic w_unusedSub;

  assign w_unusedSub = iSub;
  assign w_initCarry = iC;
  assign w_byteB     = r_opB[8*r_idx +: 8];
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      c_S_IDLE: if (iValid)     w_stateNext = c_S_RUN;
      c_S_RUN:  if (w_lastByte) w_stateNext = c_S_DONE;
      // iValid is deliberately ignored here: no same-cycle re-accept.
      c_S_DONE: if (iReady)     w_stateNext = c_S_IDLE;
      default:                  w_stateNext = c_S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode; the Adder sees zeros whenever no slice is in flight.
  // --------------------------------------------------------------------------
  always_comb begin
    oReady = 1'b0;
    oValid = 1'b0;
    oAdd_a = 8'd0;
    oAdd_b = 8'd0;
    oAdd_c = 1'b0;
    case (r_state)
      c_S_IDLE: oReady = 1'b1;
      c_S_RUN: begin
        oAdd_a = r_opA[8*r_idx +: 8];
        oAdd_b = w_byteB;
        oAdd_c = r_carry;
      end
      c_S_DONE: oValid = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand latch on accept, one result byte per RUN cycle.
  // oSum is not cleared between operations; it is meaningful only in DONE.
  // --------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_opA      <= '0;
      r_opB      <= '0;
      r_sum      <= '0;
      r_carryOut <= 1'b0;
    end else if (w_accept) begin
      r_opA   <= iA;
      r_opB   <= iB;
      r_carry <= w_initCarry;
      r_idx   <= '0;
    end else if (r_state == c_S_RUN) begin
      r_sum[8*r_idx +: 8] <= iAdd_sum;
      r_carry             <= iAdd_cout;
      if (w_lastByte) begin
        r_carryOut <= iAdd_cout;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign oSum   = r_sum;
  assign oCarry = r_carryOut;

endmodule
`default_nettype wire

// File: tb/tb_adder_byte_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_byte_seq
// Purpose  : Self-checking bench for adder_byte_seq (NBYTES=4) with a
//            behavioural 8-bit Adder attached to the sequencer's adder ports.
//            Expected results come from plain wide arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_byte_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;
`ifdef ADD_BYTE_SEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         iClk   = 1'b0;
  logic         iRst_n = 1'b0;
  logic         iValid = 1'b0;
  logic         iC     = 1'b0;
  logic         iSub   = 1'b0;
  logic         iReady = 1'b0;
  logic [W-1:0] iA     = '0;
  logic [W-1:0] iB     = '0;

  logic         oReady;
  logic         oValid;
  logic         oCarry;
  logic [W-1:0] oSum;
  logic [7:0]   oAdd_a;
  logic [7:0]   oAdd_b;
  logic         oAdd_c;
  logic [7:0]   addSum;
  logic         addCout;

  int vectors     = 0;
  int miscompares = 0;

  always #5 iClk = ~iClk;

  // Behavioural stand-in for the external 8-bit Adder.
  assign {addCout, addSum} = {1'b0, oAdd_a} + {1'b0, oAdd_b} + {8'd0, oAdd_c};

  adder_byte_seq #(.NBYTES(NB)) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iValid    (iValid),
    .oReady    (oReady),
    .iA        (iA),
    .iB        (iB),
    .iC        (iC),
    .iSub      (iSub),
    .oAdd_a    (oAdd_a),
    .oAdd_b    (oAdd_b),
    .oAdd_c    (oAdd_c),
    .iAdd_sum  (addSum),
    .iAdd_cout (addCout),
    .oValid    (oValid),
    .iReady    (iReady),
    .oSum      (oSum),
    .oCarry    (oCarry)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result {carry, sum} from whole-word arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic c, s);
    longint d;
    if (s && SUB_EN) begin
      d = longint'(a) - longint'(b) - longint'(c);
      return {(d >= 0) ? 1'b1 : 1'b0, d[W-1:0]};
    end
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Carry expected at the adder input for slice k: carry out of the low k bytes.
  function automatic logic carryInto(input logic [W-1:0] a, b, input logic c, s, input int k);
    logic [W-1:0]    bx;
    longint unsigned m, lo, cin;
    bx  = (s && SUB_EN) ? ~b : b;
    cin = (s && SUB_EN) ? {63'd0, ~c} : {63'd0, c};
    m   = (64'd1 << (8 * k)) - 64'd1;
    lo  = ({32'd0, a} & m) + ({32'd0, bx} & m) + cin;
    return lo[8 * k];
  endfunction

  // Called #1 after the accepting edge; walks the RUN cycles and checks DONE.
  task automatic runBody(input logic [W-1:0] a, b, input logic c, s, input string tag);
    logic [W-1:0] bx;
    bx = (s && SUB_EN) ? ~b : b;
    for (int k = 0; k < NB; k++) begin
      check({tag, "/run_valid"}, {63'd0, oValid}, 64'd0);
      check({tag, "/run_ready"}, {63'd0, oReady}, 64'd0);
      check({tag, "/add_a"}, {56'd0, oAdd_a}, {56'd0, a[8*k +: 8]});
      check({tag, "/add_b"}, {56'd0, oAdd_b}, {56'd0, bx[8*k +: 8]});
      check({tag, "/add_c"}, {63'd0, oAdd_c}, {63'd0, carryInto(a, b, c, s, k)});
      @(posedge iClk); #1;
    end
    check({tag, "/done_valid"}, {63'd0, oValid}, 64'd1);
    check({tag, "/result"}, {31'd0, oCarry, oSum}, {31'd0, model(a, b, c, s)});
  endtask

  // Called #1 after an edge with the DUT idle.
  task automatic issue(input logic [W-1:0] a, b, input logic c, s, input string tag);
    iA = a; iB = b; iC = c; iSub = s; iValid = 1'b1;
    check({tag, "/idle_ready"}, {63'd0, oReady}, 64'd1);
    @(posedge iClk); #1;
    iValid = 1'b0;
    runBody(a, b, c, s, tag);
  endtask

  task automatic release_result(input string tag);
    iReady = 1'b1;
    @(posedge iClk); #1;
    iReady = 1'b0;
    check({tag, "/rel_valid"}, {63'd0, oValid}, 64'd0);
    check({tag, "/rel_ready"}, {63'd0, oReady}, 64'd1);
  endtask

  initial begin
    logic [W:0]   exp;
    logic [W-1:0] ra, rb;
    logic         rc, rs;

    // Reset values
    #1;
    check("rst/ready", {63'd0, oReady}, 64'd1);
    check("rst/valid", {63'd0, oValid}, 64'd0);
    check("rst/sum", {31'd0, oCarry, oSum}, 64'd0);
    check("rst/add", {47'd0, oAdd_a, oAdd_b, oAdd_c}, 64'd0);
    @(negedge iClk); iRst_n = 1'b1;
    @(posedge iClk); #1;

    // Directed cases
    issue(32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, "t1");
    check("t1/const", {31'd0, oCarry, oSum}, {31'd0, 1'b0, 32'h0000_0010});
    release_result("t1");

    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "t2");
    check("t2/const", {31'd0, oCarry, oSum}, {31'd0, 1'b1, 32'h0000_0000});
    release_result("t2");

    issue(32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, "t3");
    check("t3/const", {31'd0, oCarry, oSum}, {31'd0, 1'b0, 32'h0000_0101});
    release_result("t3");

    // Backpressure: new request held while result waits in DONE
    issue(32'h8000_00AA, 32'h8000_0055, 1'b1, 1'b0, "bp");
    exp = model(32'h8000_00AA, 32'h8000_0055, 1'b1, 1'b0);
    iA = 32'hCAFE_0001; iB = 32'h0101_FFFF; iC = 1'b0; iSub = 1'b0; iValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge iClk); #1;
      check("bp/hold_valid", {63'd0, oValid}, 64'd1);
      check("bp/hold_ready", {63'd0, oReady}, 64'd0);
      check("bp/hold_result", {31'd0, oCarry, oSum}, {31'd0, exp});
    end
    iReady = 1'b1;
    @(posedge iClk); #1;
    iReady = 1'b0;
    check("bp/idle_valid", {63'd0, oValid}, 64'd0);
    check("bp/idle_ready", {63'd0, oReady}, 64'd1);
    @(posedge iClk); #1;
    iValid = 1'b0;
    runBody(32'hCAFE_0001, 32'h0101_FFFF, 1'b0, 1'b0, "bp2");
    release_result("bp2");

    // Reset in the middle of RUN aborts the operation
    iA = 32'h1234_5678; iB = 32'h1111_1111; iC = 1'b0; iSub = 1'b0; iValid = 1'b1;
    @(posedge iClk); #1;
    iValid = 1'b0;
    @(posedge iClk); @(posedge iClk); #1;
    iRst_n = 1'b0;
    #1;
    check("mrst/valid", {63'd0, oValid}, 64'd0);
    check("mrst/ready", {63'd0, oReady}, 64'd1);
    check("mrst/sum", {31'd0, oCarry, oSum}, 64'd0);
    check("mrst/add", {47'd0, oAdd_a, oAdd_b, oAdd_c}, 64'd0);
    @(negedge iClk); iRst_n = 1'b1;
    for (int i = 0; i < NB + 1; i++) begin
      @(posedge iClk); #1;
      check("mrst/no_valid", {63'd0, oValid}, 64'd0);
    end
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, "t5");
    check("t5/const", {31'd0, oCarry, oSum}, {31'd0, 1'b0, 32'h2345_6789});
    release_result("t5");

    // Subtract select (add-only builds ignore iSub)
    issue(32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1, "s1");
    check("s1/const", {31'd0, oCarry, oSum},
          SUB_EN ? {31'd0, 1'b1, 32'h0000_000F} : {31'd0, 1'b0, 32'h0000_0011});
    release_result("s1");

    issue(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, "s2");
    check("s2/const", {31'd0, oCarry, oSum},
          SUB_EN ? {31'd0, 1'b0, 32'hFFFF_FFFF} : {31'd0, 1'b0, 32'h0000_0001});
    release_result("s2");

    // Randomized operations with random result-side stalls
    for (int n = 0; n < 30; n++) begin
      ra = $urandom;
      rb = (n % 5 == 0) ? ~ra : $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      issue(ra, rb, rc, rs, "rnd");
      exp = model(ra, rb, rc, rs);
      for (int d = 0; d < int'($urandom_range(0, 2)); d++) begin
        @(posedge iClk); #1;
        check("rnd/stall_result", {31'd0, oCarry, oSum}, {31'd0, exp});
      end
      release_result("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
